dump_status_poller: RTL



---
 rtl/dump_poll_pkg.sv | 22 ++
 rtl/dump_poll_pri_enc.sv | 19 +
 rtl/dump_status_poller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dump_poll_pkg.sv
// Shared types and constants for the dump status poller.
// DUMP_POLL_HEADER_EN adds the HDR state used for the per-sweep header beat.
package dump_poll_pkg;

  localparam int unsigned NUM_CH_MAX      = 12;
  localparam logic [7:0]  STATUS_ADDR_DEF = 8'hE1;
  localparam logic [3:0]  HDR_CHAN        = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    STAT_RD,
    STAT_GAP,
`ifdef DUMP_POLL_HEADER_EN
    HDR,
`endif
    SEL,
    CH_RD,
    CH_GAP,
    PUSH
  } state_t;

endpackage

// File: rtl/dump_poll_pri_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit of i_vec (0 if none).
module dump_poll_pri_enc
  import dump_poll_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_MAX
) (
  input  logic [NUM_CH-1:0] i_vec,
  output logic [3:0]        o_idx
);

  always_comb begin
    o_idx = '0;
    // Scan downwards so the lowest set bit is the final assignment.
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (i_vec[i-1]) o_idx = 4'(i - 1);
    end
  end

endmodule

// File: rtl/dump_status_poller.sv
// Polls the clear-on-read new-data status register and streams each flagged channel's dump words.
// Define DUMP_POLL_HEADER_EN to emit a header beat (chan 4'hF, status word) before each sweep.
module dump_status_poller
  import dump_poll_pkg::*;
#(
  parameter int unsigned NUM_CH        = 12,
  parameter logic [7:0]  STATUS_ADDR   = STATUS_ADDR_DEF,
  parameter logic [7:0]  CH_BASE       = 8'h00,
  parameter logic [7:0]  CH_STRIDE     = 8'h10,
  parameter int unsigned WORDS_PER_CH  = 4,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned POLL_INTERVAL = 1000
) (
  input  logic        clk,
  input  logic        hw_rstn,
  input  logic        enable,
  output logic        chip_select,
  output logic        read,
  output logic        write,
  output logic [7:0]  address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_chan,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned    CW         = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(POLL_INTERVAL - 1);
  localparam logic [3:0]     LAST_WORD  = 4'(WORDS_PER_CH - 1);
  localparam logic [7:0]     LAT_LAST   = 8'(RD_LAT);

  state_t                    r_state, w_state_n;
  logic [CW-1:0]             r_cnt, w_cnt_n;
  logic [7:0]                r_lat, w_lat_n;
  logic [NUM_CH-1:0]         r_pending, w_pending_n, w_pending_clr;
  logic [3:0]                r_ch, w_ch_n, w_idx;
  logic [3:0]                r_word, w_word_n;
  logic [NUM_CH_MAX-1:0]     r_status, w_status_n;
  logic                      r_cs, w_cs_n;
  logic [7:0]                r_addr, w_addr_n;
  logic [31:0]               r_out_data, w_out_data_n;
  logic                      r_out_valid, w_out_valid_n;
  logic [3:0]                r_out_chan, w_out_chan_n;
  logic                      r_out_last, w_out_last_n;
  logic                      r_busy, w_busy_n;

  function automatic logic [7:0] ch_addr(input logic [3:0] ch, input logic [3:0] word);
    return CH_BASE + 8'(ch) * CH_STRIDE + 8'(word);
  endfunction

  dump_poll_pri_enc #(.NUM_CH(NUM_CH)) u_pri_enc (
    .i_vec (r_pending),
    .o_idx (w_idx)
  );

  assign w_pending_clr = r_pending & ~(NUM_CH'(1) << r_ch);

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_lat_n       = r_lat;
    w_pending_n   = r_pending;
    w_ch_n        = r_ch;
    w_word_n      = r_word;
    w_status_n    = r_status;
    w_addr_n      = r_addr;
    w_out_data_n  = r_out_data;
    w_out_chan_n  = r_out_chan;
    w_out_last_n  = r_out_last;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          if (r_cnt == '0) begin
            w_state_n = STAT_RD;
            w_cnt_n   = CNT_RELOAD;
            w_addr_n  = STATUS_ADDR;
            w_lat_n   = '0;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      end
      STAT_RD: begin
        if (r_lat == LAT_LAST) begin
          w_status_n = read_data[NUM_CH_MAX-1:0];
          w_state_n  = STAT_GAP;
        end else begin
          w_lat_n = r_lat + 8'd1;
        end
      end
      STAT_GAP: begin
        w_pending_n = r_status[NUM_CH-1:0];
        if (r_status[NUM_CH-1:0] == '0) begin
          w_state_n = IDLE;
        end else begin
`ifdef DUMP_POLL_HEADER_EN
          w_state_n    = HDR;
          w_out_data_n = {20'h0, r_status};
          w_out_chan_n = HDR_CHAN;
          w_out_last_n = 1'b1;
`else
          w_state_n = SEL;
`endif
        end
      end
`ifdef DUMP_POLL_HEADER_EN
      HDR: begin
        if (out_ready) w_state_n = SEL;
      end
`endif
      SEL: begin
        w_ch_n    = w_idx;
        w_word_n  = '0;
        w_addr_n  = ch_addr(w_idx, 4'd0);
        w_lat_n   = '0;
        w_state_n = CH_RD;
      end
      CH_RD: begin
        if (r_lat == LAT_LAST) begin
          w_out_data_n = read_data;
          w_state_n    = CH_GAP;
        end else begin
          w_lat_n = r_lat + 8'd1;
        end
      end
      CH_GAP: begin
        w_out_chan_n = r_ch;
        w_out_last_n = (r_word == LAST_WORD);
        w_state_n    = PUSH;
      end
      PUSH: begin
        if (out_ready) begin
          if (!r_out_last) begin
            w_word_n  = r_word + 4'd1;
            w_addr_n  = ch_addr(r_ch, r_word + 4'd1);
            w_lat_n   = '0;
            w_state_n = CH_RD;
          end else begin
            w_pending_n = w_pending_clr;
            w_state_n   = (w_pending_clr != '0) ? SEL : IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with the state they belong to.
    w_cs_n        = (w_state_n == STAT_RD) || (w_state_n == CH_RD);
    w_out_valid_n = (w_state_n == PUSH);
`ifdef DUMP_POLL_HEADER_EN
    if (w_state_n == HDR) w_out_valid_n = 1'b1;
`endif
    w_busy_n      = (w_state_n != IDLE);
  end

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      r_state     <= IDLE;
      r_cnt       <= CNT_RELOAD;
      r_lat       <= '0;
      r_pending   <= '0;
      r_ch        <= '0;
      r_word      <= '0;
      r_status    <= '0;
      r_cs        <= 1'b0;
      r_addr      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_lat       <= w_lat_n;
      r_pending   <= w_pending_n;
      r_ch        <= w_ch_n;
      r_word      <= w_word_n;
      r_status    <= w_status_n;
      r_cs        <= w_cs_n;
      r_addr      <= w_addr_n;
      r_out_data  <= w_out_data_n;
      r_out_valid <= w_out_valid_n;
      r_out_chan  <= w_out_chan_n;
      r_out_last  <= w_out_last_n;
      r_busy      <= w_busy_n;
    end
  end

  assign chip_select = r_cs;
  assign read        = r_cs;
  assign write       = 1'b0;
  assign write_data  = '0;
  assign address     = r_addr;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_chan    = r_out_chan;
  assign out_last    = r_out_last;
  assign busy        = r_busy;

endmodule
